// File: rtl/bus16_reg_responder.sv
// bus16_reg_responder
// Register-bus responder below the UART bus bridge. Decodes single-cycle
// chip-select transactions into a small register bank and returns read data
// through a fixed-depth pipeline of RD_LATENCY cycles (legal range 1-4).
//
// Register map (index = i_Bus_Addr8[3:1], bank aliases every 16 bytes)
//   0  0x00  ID        read-only, ID_VALUE
//   1  0x02  SCRATCH   read/write
//   2  0x04  CTRL      read/write, drives o_Ctrl
//   3  0x06  STATUS    sticky event bits, write-1-to-clear
//   4  0x08  IRQ_EN    read/write
//   5  0x0A  FREE_CNT  free-running, any write reloads zero
//   6-7      unmapped  reads 16'hDEAD, writes ignored

module bus16_reg_responder #(
  parameter logic [15:0] ID_VALUE   = 16'hB016,
  parameter int          RD_LATENCY = 1,
  parameter logic [15:0] CTRL_RST   = 16'h0000
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst_L,
  input  logic        i_Bus_CS,
  input  logic        i_Bus_Wr_Rd_n,
  input  logic [15:0] i_Bus_Addr8,
  input  logic [15:0] i_Bus_Wr_Data,
  output logic [15:0] o_Bus_Rd_Data,
  output logic        o_Bus_Rd_DV,
  input  logic [15:0] i_Event,
  output logic [15:0] o_Ctrl,
  output logic        o_Irq
);

  localparam logic [2:0] IDX_ID       = 3'd0;
  localparam logic [2:0] IDX_SCRATCH  = 3'd1;
  localparam logic [2:0] IDX_CTRL     = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
  localparam logic [2:0] IDX_IRQ_EN   = 3'd4;
  localparam logic [2:0] IDX_FREE_CNT = 3'd5;

  localparam logic [15:0] UNMAPPED_DATA = 16'hDEAD;

  logic [15:0] r_scratch;
  logic [15:0] r_ctrl;
  logic [15:0] r_status;
  logic [15:0] r_irq_en;
  logic [15:0] r_free_cnt;
  logic        r_irq;

  logic        r_dv_pipe   [RD_LATENCY];
  logic [15:0] r_data_pipe [RD_LATENCY];

  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_rd_mux;
  logic [15:0] w_status_clr;

  assign w_idx = i_Bus_Addr8[3:1];
  assign w_wr  = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign w_rd  = i_Bus_CS & ~i_Bus_Wr_Rd_n;

  // W1C mask only exists on a write to STATUS
  assign w_status_clr = (w_wr && (w_idx == IDX_STATUS)) ? i_Bus_Wr_Data : 16'h0000;

  // Read mux sees register state before the CS edge
  always_comb begin
    w_rd_mux = UNMAPPED_DATA;
    case (w_idx)
      IDX_ID:       w_rd_mux = ID_VALUE;
      IDX_SCRATCH:  w_rd_mux = r_scratch;
      IDX_CTRL:     w_rd_mux = r_ctrl;
      IDX_STATUS:   w_rd_mux = r_status;
      IDX_IRQ_EN:   w_rd_mux = r_irq_en;
      IDX_FREE_CNT: w_rd_mux = r_free_cnt;
      default:      w_rd_mux = UNMAPPED_DATA;
    endcase
  end

  // Plain read/write registers
  always_ff @(posedge i_Bus_Clk) begin
    if (!i_Bus_Rst_L) begin
      r_scratch <= 16'h0000;
      r_ctrl    <= CTRL_RST;
      r_irq_en  <= 16'h0000;
    end else if (w_wr) begin
      if (w_idx == IDX_SCRATCH) r_scratch <= i_Bus_Wr_Data;
      if (w_idx == IDX_CTRL)    r_ctrl    <= i_Bus_Wr_Data;
      if (w_idx == IDX_IRQ_EN)  r_irq_en  <= i_Bus_Wr_Data;
    end
  end

  // Sticky status: an event in the same cycle as its clear wins
  always_ff @(posedge i_Bus_Clk) begin
    if (!i_Bus_Rst_L) begin
      r_status <= 16'h0000;
    end else begin
      r_status <= (r_status & ~w_status_clr) | i_Event;
    end
  end

  // Free-running counter; a write reloads zero on its own edge
  always_ff @(posedge i_Bus_Clk) begin
    if (!i_Bus_Rst_L) begin
      r_free_cnt <= 16'h0000;
    end else if (w_wr && (w_idx == IDX_FREE_CNT)) begin
      r_free_cnt <= 16'h0000;
    end else begin
      r_free_cnt <= r_free_cnt + 16'h0001;
    end
  end

  // Interrupt is registered, so it trails STATUS/IRQ_EN by one cycle
  always_ff @(posedge i_Bus_Clk) begin
    if (!i_Bus_Rst_L) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_irq_en);
    end
  end

  // Read-return shift pipeline; data is zeroed in bubbles so the output idles at 0
  always_ff @(posedge i_Bus_Clk) begin
    if (!i_Bus_Rst_L) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_dv_pipe[i]   <= 1'b0;
        r_data_pipe[i] <= 16'h0000;
      end
    end else begin
      r_dv_pipe[0]   <= w_rd;
      r_data_pipe[0] <= w_rd ? w_rd_mux : 16'h0000;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_dv_pipe[i]   <= r_dv_pipe[i-1];
        r_data_pipe[i] <= r_data_pipe[i-1];
      end
    end
  end

  assign o_Bus_Rd_DV   = r_dv_pipe[RD_LATENCY-1];
  assign o_Bus_Rd_Data = r_data_pipe[RD_LATENCY-1];
  assign o_Ctrl        = r_ctrl;
  assign o_Irq         = r_irq;

endmodule

// File: doc/bus16_reg_responder.md
Name: bus16_reg_responder

Overview:
- Bus-side responder for the 16-bit register bus driven by the UART bus bridge.
- Decodes one-cycle chip-select transactions and implements a small register bank: ID, scratch, control, sticky status with write-1-to-clear, IRQ enable and a free-running counter.
- Returns read data with a fixed, parameterised latency on o_Bus_Rd_Data/o_Bus_Rd_DV.
- Sits one level below the bridge; higher-level chip-select decoding is external.

Parameters:
- ID_VALUE, 16'hB016, value returned by the read-only ID register.
- RD_LATENCY, 1, clock cycles from CS sample to o_Bus_Rd_DV; legal range 1-4.
- CTRL_RST, 16'h0000, reset value of the CTRL register.

Ports:
- i_Bus_Clk  in  1  bus clock; all logic on the rising edge.
- i_Bus_Rst_L  in  1  synchronous active-low reset.
- i_Bus_CS  in  1  transaction strobe; each cycle high is one transaction.
- i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read; qualified by CS.
- i_Bus_Addr8  in  16  byte address.
- i_Bus_Wr_Data  in  16  write data.
- o_Bus_Rd_Data  out  16  read data; valid only while o_Bus_Rd_DV is high.
- o_Bus_Rd_DV  out  1  one-cycle read-data-valid pulse.
- i_Event  in  16  event pulses; each high bit sets the matching STATUS bit.
- o_Ctrl  out  16  CTRL register contents.
- o_Irq  out  1  registered OR of (STATUS & IRQ_EN).

Behaviour:
- Clock and reset: single clock i_Bus_Clk. Reset i_Bus_Rst_L is synchronous and active-low.
- Reset values:
  - o_Bus_Rd_DV = 0, o_Bus_Rd_Data = 0, o_Irq = 0.
  - o_Ctrl = CTRL_RST; SCRATCH, STATUS, IRQ_EN and FREE_CNT = 0.
  - Read pipeline cleared.
- Decode:
  - Register index = i_Bus_Addr8[3:1]. Bit 0 is ignored (16-bit registers, byte address). Bits [15:4] are ignored, so the bank aliases every 16 bytes.
  - Index 0 (0x00) ID: read-only; returns ID_VALUE; writes ignored.
  - Index 1 (0x02) SCRATCH: read/write.
  - Index 2 (0x04) CTRL: read/write; drives o_Ctrl directly from the register, taking effect the cycle after the write edge.
  - Index 3 (0x06) STATUS: sticky. Set by i_Event bits; a write clears every bit written as 1 (W1C).
  - Index 4 (0x08) IRQ_EN: read/write.
  - Index 5 (0x0A) FREE_CNT: increments every cycle and wraps 16'hFFFF -> 16'h0000. Any write loads 0 on that edge; counting resumes on the next edge.
  - Index 6-7: unmapped. Reads return 16'hDEAD; writes ignored.
- Write: takes effect on the same edge CS is sampled high with i_Bus_Wr_Rd_n = 1. No response pulse is generated.
- Read:
  - Data is captured from register state as it stands before the CS edge.
  - It is delivered through a RD_LATENCY-deep shift pipeline: o_Bus_Rd_DV is high exactly RD_LATENCY cycles after the CS cycle, for one cycle.
  - o_Bus_Rd_Data returns to 0 when DV is low.
  - Back-to-back reads on consecutive cycles yield consecutive DV pulses in order; no stall and no backpressure.
- STATUS update per cycle: next = (STATUS & ~clear_mask) | i_Event. The set has priority when an event and a W1C clear hit the same bit in the same cycle.
- IRQ: o_Irq is registered from (STATUS & IRQ_EN) != 0, so it lags register changes by one cycle.
- Reset mid-transaction: any in-flight read is discarded; no DV pulse is emitted after reset deasserts.
- CS held high for N cycles = N transactions. For a write this is idempotent, except W1C and FREE_CNT, which are re-applied each cycle.

Test Plan:
- Reset, then read 0x00 with RD_LATENCY=1 -> o_Bus_Rd_DV pulses exactly 1 cycle after CS; data 16'hB016; DV low before and after.
- Write 0x02 = 16'h1234, read 0x02, read 0x03 (alias), read 0x12 (alias) -> three DV pulses, each with 16'h1234.
- Pulse i_Event = 16'h0005; set IRQ_EN = 16'h0004 -> o_Irq = 1. Write 0x06 = 16'h0004 on the same cycle i_Event[2] pulses again -> STATUS stays 16'h0005, o_Irq stays 1. Clear with no event -> STATUS = 16'h0001, o_Irq = 0 one cycle later.
- RD_LATENCY=3, back-to-back reads of 0x04, 0x0C, 0x0E (CTRL=16'hA5A5) -> DV on cycles +3, +4, +5 carrying 16'hA5A5, 16'hDEAD, 16'hDEAD.
- Write 0x0A, then read 0x0A 10 cycles after the write edge -> returns 16'h0009 (9 increments on edges 1-9 between write and read). Preload via run to 16'hFFFF -> next value 16'h0000.
- Issue a read with RD_LATENCY=4 and assert i_Bus_Rst_L=0 for one cycle two cycles later -> no DV pulse ever; o_Ctrl = CTRL_RST; o_Irq = 0.
